ram_responder: RTL and testbench

//  Synthesizable memory responder for the Phaethon ALU data/instruction bus.

---
 rtl/phaethon_mem_pkg.sv | 17 +
 rtl/ram_byte_array.sv | 59 +++++
 rtl/ram_responder.sv | 128 ++++++++++++
 tb/tb_ram_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/phaethon_mem_pkg.sv
// Shared definitions for the Phaethon ALU memory responder.
//   - FSM state encoding (2-bit) used by ram_responder.
//   - Word width in bytes and the default RAM geometry.
package phaethon_mem_pkg;

  localparam int RAM_WORD_BYTES  = 4;
  localparam int DEFAULT_RAMSIZE = 256;
  localparam int DEFAULT_ADDR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACK   = 2'd3
  } mem_state_e;

endpackage

// File: rtl/ram_byte_array.sv
// Byte-addressed storage (RAMSIZE x 8) with no reset logic.
// Ports:
//   clk          clock; all writes on posedge
//   i_wr_en      commit a 4-byte word write this edge
//   i_word_addr  byte address of the word (wraps modulo RAMSIZE)
//   i_wr_data    write data, byte0 = [7:0]
//   o_rd_data    combinational 4-byte wrapped read at i_word_addr
//   i_load_en    byte preload strobe (ignored for a byte hit by i_wr_en)
//   i_load_addr  preload byte address
//   i_load_data  preload byte value
module ram_byte_array
  import phaethon_mem_pkg::*;
#(
  parameter int RAMSIZE = DEFAULT_RAMSIZE,
  parameter int ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_word_addr,
  input  logic [31:0]       i_wr_data,
  output logic [31:0]       o_rd_data,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [7:0]        i_load_data
);

  logic [RAMSIZE*8-1:0] w_mem_flat;

  genvar gi;

  // Each byte decides for itself whether it lies inside the 4-byte window.
  // The offset is computed modulo RAMSIZE, so a window that straddles the
  // top of memory wraps naturally and all four bytes commit on one edge.
  generate
    for (gi = 0; gi < RAMSIZE; gi++) begin : g_byte
      logic [7:0]        r_byte;
      logic [ADDR_W-1:0] w_ofs;

      assign w_ofs = ADDR_W'(gi) - i_word_addr;

      always_ff @(posedge clk) begin
        if (i_wr_en && (w_ofs < ADDR_W'(RAM_WORD_BYTES))) begin
          r_byte <= i_wr_data[{w_ofs[1:0], 3'b000} +: 8];
        end else if (i_load_en && (i_load_addr == ADDR_W'(gi))) begin
          r_byte <= i_load_data;
        end
      end

      assign w_mem_flat[gi*8 +: 8] = r_byte;
    end

    for (gi = 0; gi < RAM_WORD_BYTES; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_idx;
      assign w_idx = i_word_addr + ADDR_W'(gi);
      assign o_rd_data[gi*8 +: 8] = w_mem_flat[{w_idx, 3'b000} +: 8];
    end
  endgenerate

endmodule

// File: rtl/ram_responder.sv
// Memory responder for the Phaethon ALU bus: 32-bit little-endian word
// reads/writes into byte-addressed RAM, with a byte preload port.
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   readReq/writeReq  level requests, held until ack (write wins if both)
//   ramAddress        word byte address; bits above ADDR_W ignored
//   ramOut            write data from initiator
//   ramValue          read data, valid with readAck and held afterwards
//   readAck/writeAck  one-cycle completion pulses
//   busy              high whenever the FSM is not idle
//   load_en/addr/data byte preload, dropped while a bus write commits
module ram_responder
  import phaethon_mem_pkg::*;
#(
  parameter int RAMSIZE = DEFAULT_RAMSIZE,
  parameter int ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readReq,
  input  logic              writeReq,
  input  logic [31:0]       ramAddress,
  input  logic [31:0]       ramOut,
  output logic [31:0]       ramValue,
  output logic              readAck,
  output logic              writeAck,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data
);

  mem_state_e        r_state;
  mem_state_e        w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [31:0]       r_ram_value;
  logic              r_read_ack;
  logic              r_write_ack;
  logic              w_mem_we;
  logic              w_load_en;
  logic              w_busy;
  logic [31:0]       w_rd_data;
  logic              w_unused_addr_hi;

  assign w_unused_addr_hi = ^ramAddress[31:ADDR_W];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (writeReq) begin
          w_state_next = ST_WRITE;
        end else if (readReq) begin
          w_state_next = ST_READ;
        end
      end
      ST_READ:  w_state_next = ST_ACK;
      ST_WRITE: w_state_next = ST_ACK;
      ST_ACK:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs. Write enable comes from the reset-cleared state
  // register, so a reset before the commit edge leaves memory untouched.
  always_comb begin
    w_busy    = (r_state != ST_IDLE);
    w_mem_we  = (r_state == ST_WRITE);
    w_load_en = load_en && (r_state != ST_WRITE);
  end

  // Request latches and registered read data / acks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_ram_value <= '0;
      r_read_ack  <= 1'b0;
      r_write_ack <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (writeReq) begin
          r_addr <= ramAddress[ADDR_W-1:0];
          r_data <= ramOut;
        end else if (readReq) begin
          r_addr <= ramAddress[ADDR_W-1:0];
        end
      end
      if (r_state == ST_READ) begin
        r_ram_value <= w_rd_data;
      end
      // Acks are high exactly during the ACK state
      r_read_ack  <= (r_state == ST_READ);
      r_write_ack <= (r_state == ST_WRITE);
    end
  end

  ram_byte_array #(
    .RAMSIZE (RAMSIZE),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .clk         (clk),
    .i_wr_en     (w_mem_we),
    .i_word_addr (r_addr),
    .i_wr_data   (r_data),
    .o_rd_data   (w_rd_data),
    .i_load_en   (w_load_en),
    .i_load_addr (load_addr),
    .i_load_data (load_data)
  );

  assign ramValue = r_ram_value;
  assign readAck  = r_read_ack;
  assign writeAck = r_write_ack;
  assign busy     = w_busy;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        readReq;
  logic        writeReq;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic [31:0] ramValue;
  logic        readAck;
  logic        writeAck;
  logic        busy;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;

  int n_checks = 0;
  int n_errors = 0;

  ram_responder #(.RAMSIZE(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .readReq    (readReq),
    .writeReq   (writeReq),
    .ramAddress (ramAddress),
    .ramOut     (ramOut),
    .ramValue   (ramValue),
    .readAck    (readAck),
    .writeAck   (writeAck),
    .busy       (busy),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    int cyc;
    cyc = 0;
    readReq = 1'b1; ramAddress = a;
    tick();
    ramAddress = a + 32'd7;  // must not affect the accepted op
    while (!readAck && cyc < 8) begin
      tick();
      cyc++;
    end
    check_eq("rd_ack_seen", 32'(readAck), 32'd1);
    d = ramValue;
    readReq = 1'b0;
    tick();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    int cyc;
    cyc = 0;
    writeReq = 1'b1; ramAddress = a; ramOut = d;
    tick();
    ramAddress = a + 32'd5; ramOut = ~d;  // must not affect the accepted op
    while (!writeAck && cyc < 8) begin
      tick();
      cyc++;
    end
    check_eq("wr_ack_seen", 32'(writeAck), 32'd1);
    writeReq = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int acks;
    reset = 1'b0; readReq = 1'b0; writeReq = 1'b0;
    ramAddress = '0; ramOut = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    // Preload under reset, then check reset state
    tick();
    load_byte(8'h10, 8'h78);
    load_byte(8'h11, 8'h56);
    load_byte(8'h12, 8'h34);
    load_byte(8'h13, 8'h12);
    check_eq("rst_ramValue", ramValue, 32'h0);
    check_eq("rst_readAck", 32'(readAck), 32'd0);
    check_eq("rst_writeAck", 32'(writeAck), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    // 1: read latency and ack width
    readReq = 1'b1; ramAddress = 32'h10;
    tick();
    check_eq("t1_busy_read", 32'(busy), 32'd1);
    check_eq("t1_ack_early", 32'(readAck), 32'd0);
    tick();
    check_eq("t1_ack", 32'(readAck), 32'd1);
    check_eq("t1_value", ramValue, 32'h12345678);
    readReq = 1'b0;
    tick();
    check_eq("t1_ack_width", 32'(readAck), 32'd0);
    check_eq("t1_value_held", ramValue, 32'h12345678);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // 2: write then reads (including unaligned) to confirm byte placement
    for (int i = 8'h1C; i <= 8'h27; i++) load_byte(8'(i), 8'h00);
    bus_write(32'h20, 32'hDEADBEEF);
    bus_read(32'h20, rd);  check_eq("t2_rd20", rd, 32'hDEADBEEF);
    bus_read(32'h21, rd);  check_eq("t2_rd21", rd, 32'h00DEADBE);
    bus_read(32'h23, rd);  check_eq("t2_rd23", rd, 32'h000000DE);
    bus_read(32'h1D, rd);  check_eq("t2_rd1D", rd, 32'hEF000000);

    // 3: readReq held high: ack every 3rd cycle, busy low only in IDLE
    readReq = 1'b1; ramAddress = 32'h10;
    acks = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (readAck) acks++;
      check_eq($sformatf("t3_ack_c%0d", k), 32'(readAck), (k % 3 == 1) ? 32'd1 : 32'd0);
      check_eq($sformatf("t3_busy_c%0d", k), 32'(busy), (k % 3 == 2) ? 32'd0 : 32'd1);
    end
    readReq = 1'b0;
    check_eq("t3_ack_count", 32'(acks), 32'd3);
    check_eq("t3_value", ramValue, 32'h12345678);

    // 4: simultaneous read & write -> write wins
    for (int i = 8'h2C; i <= 8'h37; i++) load_byte(8'(i), 8'h00);
    readReq = 1'b1; writeReq = 1'b1; ramAddress = 32'h30; ramOut = 32'hA5A5A5A5;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (writeAck) begin
        acks++;
        readReq = 1'b0; writeReq = 1'b0;
      end
      check_eq($sformatf("t4_no_rdack_c%0d", k), 32'(readAck), 32'd0);
    end
    check_eq("t4_wrack_count", 32'(acks), 32'd1);
    bus_read(32'h30, rd);  check_eq("t4_rd30", rd, 32'hA5A5A5A5);
    bus_read(32'h2E, rd);  check_eq("t4_rd2E", rd, 32'hA5A50000);
    bus_read(32'h33, rd);  check_eq("t4_rd33", rd, 32'h000000A5);

    // 5: wrap-around at top of memory
    load_byte(8'h02, 8'h99);
    load_byte(8'h03, 8'h77);
    load_byte(8'hFD, 8'h55);
    bus_write(32'h1FE, 32'h11223344);  // upper address bits ignored
    bus_read(32'hFE, rd);  check_eq("t5_rdFE", rd, 32'h11223344);
    bus_read(32'hFF, rd);  check_eq("t5_rdFF", rd, 32'h99112233);
    bus_read(32'h00, rd);  check_eq("t5_rd00", rd, 32'h77991122);
    bus_read(32'hFD, rd);  check_eq("t5_rdFD", rd, 32'h22334455);

    // 6: reset during WRITE before the commit edge
    load_byte(8'h40, 8'h01);
    load_byte(8'h41, 8'h02);
    load_byte(8'h42, 8'h03);
    load_byte(8'h43, 8'h04);
    writeReq = 1'b1; ramAddress = 32'h40; ramOut = 32'hCAFEBABE;
    tick();
    check_eq("t6_busy_write", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_rst_writeAck", 32'(writeAck), 32'd0);
    check_eq("t6_rst_ramValue", ramValue, 32'h0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    writeReq = 1'b0;
    tick();
    check_eq("t6_no_wrack", 32'(writeAck), 32'd0);
    reset = 1'b1;
    tick();
    check_eq("t6_idle_after", 32'(busy), 32'd0);
    bus_read(32'h40, rd);  check_eq("t6_mem_kept", rd, 32'h04030201);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
